i386_bus_responder: RTL and testbench
=====================================

// Module: i386_bus_responder
// PURPOSE
//  Memory-side target for the Intel80386DX local bus. Decodes ADS-started memory cycles in its address window
//  and converts each into a single req/ack transaction toward the SDRAM controller. It returns write data and
//  read data, then terminates the bus cycle with a one-cycle READY pulse. Optional one-deep address pipelining via NA.
// PARAMETERS
//  ADDR_BASE  30'h0000_0000  window base, compared against A[31:2]
//  ADDR_MASK  30'h3C00_0000  bits of A[31:2] that are compared against ADDR_BASE
//  PIPE_EN    0              1 = drive NA and accept one pending cycle
//  TIMEOUT    64             max cycles in REQ without mem_ack before forced completion (>=2)
// PORTS
//  CLK2         in     1   single clock; every rising edge is one bus sample point
//  RESET        in     1   synchronous, active-high
//  D            inout  32  CPU data bus; driven only for read data
//  A            in     30  CPU address [31:2]
//  BE           in     4   byte enables, active-low
//  WR           in     1   1 = write, 0 = read
//  DC           in     1   data/code (latched, informational)
//  MIO          in     1   1 = memory cycle; I/O cycles are never claimed
//  LOCK         in     1   locked cycle, active-low
//  ADS          in     1   address strobe, active-low
//  NA           out    1   next-address request, active-low
//  READY        out    1   cycle termination, active-low
//  BS16         out    1   tied 1 (32-bit target)
//  mem_req      out    1   transaction request, held until ack
//  mem_we       out    1   1 = write
//  mem_addr     out    30  word address
//  mem_be       out    4   byte enables, active-high (= ~BE)
//  mem_wdata    out    32  write data
//  mem_rdata    in     32  read data, valid with mem_ack
//  mem_ack      in     1   completes transaction; sampled only while mem_req=1
//  mem_lock     out    1   latched ~LOCK of current transaction
//  timeout_err  out    1   one-cycle pulse on forced completion
//  proto_err    out    1   one-cycle pulse on illegal ADS
// BEHAVIOUR
//  hit = !ADS && MIO && ((A & ADDR_MASK) == (ADDR_BASE & ADDR_MASK)); non-hits are ignored silently.
//  Reset outputs: READY=1, NA=1, BS16=1, D=Z, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
//  Reset outputs (cont.): mem_lock=0, both err=0, state=IDLE, pending cleared.
//  Reset mid-operation: RESET drops mem_req and abandons the transaction; a late mem_ack is ignored.
//  FSM states: IDLE, CAP, REQ, RDY.
//  IDLE: on hit, latch A, BE, WR, DC, LOCK -> CAP.
//  CAP: one cycle; at its ending edge latch D into mem_wdata (writes only) -> REQ.
//  REQ: mem_req=1 with latched fields stable.
//  REQ, mem_ack=1: latch mem_rdata (reads) -> RDY; mem_req=0 from next cycle.
//  REQ timeout: after TIMEOUT cycles without ack, mem_req=0, read data = 32'hFFFF_FFFF, timeout_err pulse -> RDY.
//  RDY: READY=0 exactly one cycle; D driven with read data during RDY only (reads).
//  RDY exit: pending valid -> load pending into current -> CAP; else -> IDLE.
//  Latency: ADS at edge 0, mem_req visible after edge 1, ack at edge k -> READY low between edges k and k+1.
//  Minimum: ack at edge 2 gives READY low between edges 2 and 3.
//  NA: PIPE_EN=1 -> NA=0 while state==REQ and pending empty; otherwise NA=1.
//  Pending capture: hit in CAP/REQ/RDY with PIPE_EN=1 and pending empty -> capture A/BE/WR/DC/LOCK into pending.
//  Pending write data is taken in its own CAP phase.
//  Hit while busy with PIPE_EN=0, or while pending full: proto_err pulse; ADS dropped, current cycle unaffected.
//  A simultaneous ack and pending capture are both honoured in the same edge.
//  TIMEOUT counter: clears on REQ entry; width is clog2(TIMEOUT+1).
// TESTING
//  1. Write A=0x40/4, BE=4'b0000, D=0xDEADBEEF after ADS, ack at edge 2
//     -> mem_we=1, mem_be=4'hF, mem_wdata=0xDEADBEEF, READY low between edges 2 and 3.
//  2. Read, mem_rdata=0x12345678 with ack 3 cycles after req
//     -> D=0x12345678 only while READY=0, then Z.
//  3. ADS with MIO=0, or address outside window -> no mem_req, READY stays 1.
//  4. PIPE_EN=1: second ADS while NA=0 -> pending captured; second cycle CAP starts right after first RDY;
//     third ADS while pending full -> proto_err pulse.
//  5. TIMEOUT=8, no ack -> mem_req falls after 8 cycles, timeout_err pulse, read returns 0xFFFFFFFF.
//  6. RESET asserted during REQ -> next cycle mem_req=0, READY=1, D=Z; a late ack produces no READY.

Source files
------------

// File: rtl/i386_bus_responder.sv
`default_nettype none
// ============================================================================
// i386_bus_responder : 80386DX local-bus memory target bridged to a req/ack port
// Revision 1.0
// ============================================================================
module i386_bus_responder #(
  parameter logic [29:0] ADDR_BASE = 30'h0000_0000,
  parameter logic [29:0] ADDR_MASK = 30'h3C00_0000,
  parameter bit          PIPE_EN   = 1'b0,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk2_i,
  input  logic        reset_i,
  inout  wire  [31:0] d_io,
  input  logic [29:0] a_i,
  input  logic [3:0]  be_i,
  input  logic        wr_i,
  input  logic        dc_i,
  input  logic        mio_i,
  input  logic        lock_i,
  input  logic        ads_i,
  output logic        na_o,
  output logic        ready_o,
  output logic        bs16_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        mem_lock_o,
  output logic        timeout_err_o,
  output logic        proto_err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_REQ  = 2'd2,
    S_RDY  = 2'd3
  } state_e;

  // Byte enables and lock are stored already inverted to active-high.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic        lock;
  } cyc_t;

  state_e           state_q, state_d;
  cyc_t             cur_q, cur_d;
  cyc_t             pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_dc_q, pend_dc_d;
  logic             dc_unused_q, dc_unused_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             perr_q, perr_d;

  logic             w_hit;
  logic             w_take_new;
  logic             w_take_pend;
  cyc_t             w_bus;

  assign w_hit = !ads_i && mio_i && ((a_i & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

  assign w_bus.addr = a_i;
  assign w_bus.be   = ~be_i;
  assign w_bus.wr   = wr_i;
  assign w_bus.lock = ~lock_i;

  // A hit during RDY with nothing pending is the pending slot filled and
  // drained on the same edge, so it goes straight into the current cycle.
  assign w_take_new  = w_hit && ((state_q == S_IDLE) ||
                                 (PIPE_EN && (state_q == S_RDY) && !pend_vld_q));
  assign w_take_pend = w_hit && PIPE_EN && !pend_vld_q &&
                       ((state_q == S_CAP) || (state_q == S_REQ));

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    pend_dc_d   = pend_dc_q;
    dc_unused_d = dc_unused_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    terr_d      = 1'b0;
    perr_d      = w_hit && !w_take_new && !w_take_pend;

    case (state_q)
      S_IDLE: begin
        if (w_take_new) begin
          cur_d       = w_bus;
          dc_unused_d = dc_i;
          state_d     = S_CAP;
        end
      end
      S_CAP: begin
        if (cur_q.wr) begin
          wdata_d = d_io;
        end
        cnt_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack_i) begin
          if (!cur_q.wr) begin
            rdata_d = mem_rdata_i;
          end
          state_d = S_RDY;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'hFFFF_FFFF;
          terr_d  = 1'b1;
          state_d = S_RDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RDY: begin
        if (pend_vld_q) begin
          cur_d       = pend_q;
          dc_unused_d = pend_dc_q;
          pend_vld_d  = 1'b0;
          state_d     = S_CAP;
        end else if (w_take_new) begin
          cur_d       = w_bus;
          dc_unused_d = dc_i;
          state_d     = S_CAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_take_pend) begin
      pend_d     = w_bus;
      pend_dc_d  = dc_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk2_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_dc_q   <= 1'b0;
      dc_unused_q <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      pend_dc_q   <= pend_dc_d;
      dc_unused_q <= dc_unused_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
      perr_q      <= perr_d;
    end
  end

  assign d_io          = ((state_q == S_RDY) && !cur_q.wr) ? rdata_q : 32'hzzzz_zzzz;
  assign ready_o       = (state_q != S_RDY);
  assign na_o          = !(PIPE_EN && (state_q == S_REQ) && !pend_vld_q);
  assign bs16_o        = 1'b1;
  assign mem_req_o     = (state_q == S_REQ);
  assign mem_we_o      = cur_q.wr;
  assign mem_addr_o    = cur_q.addr;
  assign mem_be_o      = cur_q.be;
  assign mem_lock_o    = cur_q.lock;
  assign mem_wdata_o   = wdata_q;
  assign timeout_err_o = terr_q;
  assign proto_err_o   = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_i386_bus_responder.sv
`default_nettype none
// Self-checking bench for i386_bus_responder (pipelined build, short timeout).
module tb_i386_bus_responder;

  localparam logic [29:0] BASE = 30'h0000_0000;
  localparam logic [29:0] MASK = 30'h3C00_0000;
  localparam int          TO   = 8;

  typedef struct {
    bit          mio;
    logic [29:0] a;
    logic [3:0]  be_n;
    bit          wr;
    bit          lock_n;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_edge;
    bit          exp_hit;
    logic [3:0]  exp_be;
    logic [31:0] exp_rd;
    bit          exp_terr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [31:0] d;
  logic [31:0] tb_d = '0;
  logic        tb_den = 1'b0;
  logic [29:0] a = '0;
  logic [3:0]  be_n = 4'hF;
  logic        wr = 1'b0, dc = 1'b0, mio = 1'b0, lock_n = 1'b1, ads = 1'b1;
  logic        na, ready, bs16, mem_req, mem_we, mem_lock, terr, perr;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  vec_t        tbl[8];

  assign d = tb_den ? tb_d : 32'hzzzz_zzzz;

  i386_bus_responder #(
    .ADDR_BASE(BASE), .ADDR_MASK(MASK), .PIPE_EN(1'b1), .TIMEOUT(TO)
  ) dut (
    .clk2_i(clk), .reset_i(reset), .d_io(d), .a_i(a), .be_i(be_n), .wr_i(wr),
    .dc_i(dc), .mio_i(mio), .lock_i(lock_n), .ads_i(ads), .na_o(na),
    .ready_o(ready), .bs16_o(bs16), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .mem_lock_o(mem_lock),
    .timeout_err_o(terr), .proto_err_o(perr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive zero from the bench; any DUT driver on the bus disturbs the value.
  task automatic chk_released(input string name);
    tb_d   = '0;
    tb_den = 1'b1;
    #1;
    chk(name, d, 32'h0);
    tb_den = 1'b0;
  endtask

  // Reference rules: window decode, active-high enables, ack-or-timeout completion.
  function automatic vec_t model(input vec_t s);
    vec_t v;
    v          = s;
    v.exp_hit  = s.mio && ((s.a & MASK) == (BASE & MASK));
    v.exp_be   = ~s.be_n;
    v.exp_terr = (s.ack_edge > TO + 1);
    v.exp_rd   = v.exp_terr ? 32'hFFFF_FFFF : s.rdata;
    return v;
  endfunction

  task automatic do_cycle(input vec_t v);
    int rdy_edge;
    ads = 1'b0; mio = v.mio; a = v.a; be_n = v.be_n; wr = v.wr; lock_n = v.lock_n;
    dc = 1'($urandom_range(0, 1));
    mem_rdata = v.rdata;
    tick();
    ads = 1'b1; mio = 1'b0;
    if (v.wr) begin
      tb_d = v.wdata; tb_den = 1'b1;
    end
    if (!v.exp_hit) begin
      for (int i = 0; i < 2; i++) begin
        tick();
        tb_den = 1'b0;
        chk("nohit_req", mem_req, 1'b0);
        chk("nohit_ready", ready, 1'b1);
      end
      return;
    end
    tick();
    tb_den = 1'b0;
    chk("req_rise", mem_req, 1'b1);
    chk("req_we", mem_we, v.wr);
    chk("req_addr", mem_addr, v.a);
    chk("req_be", mem_be, v.exp_be);
    chk("req_lock", mem_lock, !v.lock_n);
    chk("req_na", na, 1'b0);
    if (v.wr) chk("req_wdata", mem_wdata, v.wdata);
    rdy_edge = v.exp_terr ? TO + 1 : v.ack_edge;
    for (int e = 2; e <= rdy_edge; e++) begin
      mem_ack = (e == v.ack_edge);
      tick();
      mem_ack = 1'b0;
      if (e < rdy_edge) begin
        chk("wait_ready", ready, 1'b1);
        chk("wait_req", mem_req, 1'b1);
      end
    end
    chk("rdy_ready", ready, 1'b0);
    chk("rdy_req", mem_req, 1'b0);
    chk("rdy_terr", terr, v.exp_terr);
    if (!v.wr) chk("rdy_rdata", d, v.exp_rd);
    else chk_released("rdy_wr_bus");
    tick();
    chk("end_ready", ready, 1'b1);
    chk("end_terr", terr, 1'b0);
    chk_released("end_bus");
  endtask

  initial begin
    vec_t v;

    //        mio  a             be_n   wr  lk  wdata          rdata          ack hit be     exp_rd         terr
    tbl[0] = '{1, 30'h0000_0010, 4'h0, 1, 1, 32'hDEADBEEF, 32'h0,        2,  1, 4'hF, 32'h0,        0};
    tbl[1] = '{1, 30'h0000_0020, 4'h0, 0, 1, 32'h0,        32'h12345678, 4,  1, 4'hF, 32'h12345678, 0};
    tbl[2] = '{0, 30'h0000_0020, 4'h0, 0, 1, 32'h0,        32'h12345678, 2,  0, 4'h0, 32'h0,        0};
    tbl[3] = '{1, 30'h0400_0000, 4'h0, 0, 1, 32'h0,        32'h55AA55AA, 2,  0, 4'h0, 32'h0,        0};
    tbl[4] = '{1, 30'h03FF_FFFF, 4'hC, 0, 1, 32'h0,        32'hCAFEF00D, 3,  1, 4'h3, 32'hCAFEF00D, 0};
    tbl[5] = '{1, 30'h3FFF_FFFF, 4'h0, 1, 1, 32'h11111111, 32'h0,        2,  0, 4'h0, 32'h0,        0};
    tbl[6] = '{1, 30'h0000_0055, 4'h7, 0, 1, 32'h0,        32'h13572468, 99, 1, 4'h8, 32'hFFFFFFFF, 1};
    tbl[7] = '{1, 30'h0000_1234, 4'hA, 1, 0, 32'h0BADC0DE, 32'h0,        9,  1, 4'h5, 32'h0,        0};

    repeat (3) tick();
    chk("rst_ready", ready, 1'b1);
    chk("rst_na", na, 1'b1);
    chk("rst_bs16", bs16, 1'b1);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 30'h0);
    chk("rst_be", mem_be, 4'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_lock", mem_lock, 1'b0);
    chk("rst_terr", terr, 1'b0);
    chk("rst_perr", perr, 1'b0);
    chk_released("rst_bus");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) do_cycle(tbl[i]);

    // Pipelined pair plus an overflow ADS while the pending slot is full.
    ads = 1'b0; mio = 1'b1; a = 30'h40; wr = 1'b0; be_n = 4'h0; lock_n = 1'b1;
    tick();
    ads = 1'b1;
    tick();
    chk("p_req", mem_req, 1'b1);
    chk("p_na_low", na, 1'b0);
    ads = 1'b0; a = 30'h80; wr = 1'b1; be_n = 4'h3;
    tick();
    chk("p_na_full", na, 1'b1);
    chk("p_cur_addr", mem_addr, 30'h40);
    chk("p_cur_we", mem_we, 1'b0);
    ads = 1'b0; a = 30'hC0; wr = 1'b0;
    tick();
    chk("p_perr", perr, 1'b1);
    chk("p_req_kept", mem_req, 1'b1);
    chk("p_addr_kept", mem_addr, 30'h40);
    ads = 1'b1; mio = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 1'b0;
    chk("p_rdy1", ready, 1'b0);
    chk("p_rdata1", d, 32'h11112222);
    chk("p_perr_clr", perr, 1'b0);
    tick();
    tb_d = 32'hA5A55A5A; tb_den = 1'b1;
    chk("p_cap2_ready", ready, 1'b1);
    chk("p_cap2_req", mem_req, 1'b0);
    chk("p_cap2_addr", mem_addr, 30'h80);
    chk("p_cap2_we", mem_we, 1'b1);
    chk("p_cap2_be", mem_be, 4'hC);
    tick();
    tb_den = 1'b0;
    chk("p_req2", mem_req, 1'b1);
    chk("p_wdata2", mem_wdata, 32'hA5A55A5A);
    chk("p_na2", na, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("p_rdy2", ready, 1'b0);
    chk_released("p_rdy2_bus");
    tick();
    chk("p_idle", ready, 1'b1);

    // Ack and a new ADS on the same edge: both honoured.
    ads = 1'b0; mio = 1'b1; a = 30'h100; wr = 1'b0; be_n = 4'h0;
    tick();
    ads = 1'b1;
    tick();
    ads = 1'b0; a = 30'h104; mem_ack = 1'b1; mem_rdata = 32'h0F0F0F0F;
    tick();
    ads = 1'b1; mio = 1'b0; mem_ack = 1'b0;
    chk("s_rdy", ready, 1'b0);
    chk("s_rdata", d, 32'h0F0F0F0F);
    chk("s_perr", perr, 1'b0);
    tick();
    chk("s_cap_addr", mem_addr, 30'h104);
    chk("s_cap_ready", ready, 1'b1);
    tick();
    chk("s_req", mem_req, 1'b1);
    mem_rdata = 32'h77778888; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("s_rdata2", d, 32'h77778888);
    tick();
    chk("s_idle_ready", ready, 1'b1);
    chk("s_idle_na", na, 1'b1);

    for (int n = 0; n < 40; n++) begin
      v.mio      = ($urandom_range(0, 3) != 0);
      v.a        = 30'($urandom);
      if ($urandom_range(0, 3) != 0) v.a[29:26] = 4'h0;
      v.be_n     = 4'($urandom);
      v.wr       = 1'($urandom_range(0, 1));
      v.lock_n   = 1'($urandom_range(0, 1));
      v.wdata    = $urandom;
      v.rdata    = $urandom;
      v.ack_edge = $urandom_range(2, TO + 3);
      do_cycle(model(v));
      a = 30'($urandom);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("gap_ready", ready, 1'b1);
      end
    end

    // Reset while waiting for ack; the late ack must not complete anything.
    ads = 1'b0; mio = 1'b1; a = 30'h10; wr = 1'b0; be_n = 4'h0;
    tick();
    ads = 1'b1; mio = 1'b0;
    tick();
    chk("r_req", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_req_drop", mem_req, 1'b0);
    chk("r_ready", ready, 1'b1);
    chk_released("r_bus");
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    tick();
    mem_ack = 1'b0;
    chk("r_late_ack", ready, 1'b1);
    tick();
    chk("r_late_ack2", ready, 1'b1);
    chk("r_req_idle", mem_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
